// File: rtl/mux_n_if.sv
`timescale 1ns/1ps
// rtl/mux_n_if.sv - signal bundle for one mux_n instance: data/select in, selected bit and flags out
interface mux_n_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic [N-1:0]  x;
    logic [SW-1:0] ss;
    logic          y;
    logic          y_q;
    logic          sel_err;
    logic          err_sticky;

    modport master (output x, ss, input y, y_q, sel_err, err_sticky);
    modport slave  (input x, ss, output y, y_q, sel_err, err_sticky);
endinterface

// File: rtl/mux_n.sv
`timescale 1ns/1ps
// rtl/mux_n.sv - N-to-1 bit select with registered copy and sticky out-of-range flag
module mux_n #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    output logic          y,
    input  logic [N-1:0]  x,
    input  logic [SW-1:0] ss,
    input  logic          clk,
    input  logic          rst_n,
    output logic          y_q,
    output logic          sel_err,
    output logic          err_sticky
);
    localparam int NP = 1 << SW;

    logic [NP-1:0] x_pad;
    logic          y_d;
    logic          err_sticky_d;
    logic          err_sticky_q;

    // Zero-padding to the full select range keeps out-of-range indices at 0 without reading past x.
    always_comb begin
        x_pad        = '0;
        x_pad[N-1:0] = x;
    end

    assign y = x_pad[ss];

    generate
        if (NP == N) begin : g_full_range
            assign sel_err = 1'b0;
        end else begin : g_partial_range
            assign sel_err = (ss >= N[SW-1:0]);
        end
    endgenerate

    assign y_d          = y;
    assign err_sticky_d = err_sticky_q | sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q          <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            y_q          <= y_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_mux_n.sv
`timescale 1ns/1ps
// tb/tb_mux_n.sv - scoreboard bench for mux_n at N = 8, 5, 2, 6 driven in lockstep
module tb_mux_n;
    localparam int NI = 4;

    typedef struct {
        logic [3:0] y;
        logic [3:0] sel;
        logic [3:0] yq;
        logic [3:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] xv  [NI];
    logic [2:0] ssv [NI];

    logic [3:0] y_m, sel_m, yq_m, st_m;
    exp_t       sb [$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_bad = 0;

    mux_n_if #(.N(8)) if8 ();
    mux_n_if #(.N(5)) if5 ();
    mux_n_if #(.N(2)) if2 ();
    mux_n_if #(.N(6)) if6 ();

    assign if8.x  = xv[0];
    assign if8.ss = ssv[0];
    assign if5.x  = xv[1][4:0];
    assign if5.ss = ssv[1];
    assign if2.x  = xv[2][1:0];
    assign if2.ss = ssv[2][0];
    assign if6.x  = xv[3][5:0];
    assign if6.ss = ssv[3];

    mux_n #(.N(8)) u_n8 (.y(if8.y), .x(if8.x), .ss(if8.ss), .clk(clk), .rst_n(rst_n),
                         .y_q(if8.y_q), .sel_err(if8.sel_err), .err_sticky(if8.err_sticky));
    mux_n #(.N(5)) u_n5 (.y(if5.y), .x(if5.x), .ss(if5.ss), .clk(clk), .rst_n(rst_n),
                         .y_q(if5.y_q), .sel_err(if5.sel_err), .err_sticky(if5.err_sticky));
    mux_n #(.N(2)) u_n2 (.y(if2.y), .x(if2.x), .ss(if2.ss), .clk(clk), .rst_n(rst_n),
                         .y_q(if2.y_q), .sel_err(if2.sel_err), .err_sticky(if2.err_sticky));
    mux_n #(.N(6)) u_n6 (.y(if6.y), .x(if6.x), .ss(if6.ss), .clk(clk), .rst_n(rst_n),
                         .y_q(if6.y_q), .sel_err(if6.sel_err), .err_sticky(if6.err_sticky));

    logic [3:0] y_a, sel_a, yq_a, st_a;
    assign y_a   = {if6.y,          if2.y,          if5.y,          if8.y};
    assign sel_a = {if6.sel_err,    if2.sel_err,    if5.sel_err,    if8.sel_err};
    assign yq_a  = {if6.y_q,        if2.y_q,        if5.y_q,        if8.y_q};
    assign st_a  = {if6.err_sticky, if2.err_sticky, if5.err_sticky, if8.err_sticky};

    always #5 clk = ~clk;

    function automatic int n_of(input int k);
        case (k)
            0: return 8;
            1: return 5;
            2: return 2;
            default: return 6;
        endcase
    endfunction

    function automatic int sw_of(input int k);
        return (k == 2) ? 1 : 3;
    endfunction

    function automatic int eff_sel(input int k, input logic [2:0] s);
        return int'(s) % (1 << sw_of(k));
    endfunction

    function automatic logic ref_y(input int k, input logic [7:0] xx, input logic [2:0] s);
        int i;
        i = eff_sel(k, s);
        if (i >= n_of(k)) return 1'b0;
        return xx[i];
    endfunction

    function automatic logic ref_err(input int k, input logic [2:0] s);
        return (eff_sel(k, s) >= n_of(k)) ? 1'b1 : 1'b0;
    endfunction

    // Account for the edge just passed, apply new inputs/reset, push the expectation for this cycle.
    task automatic step(input logic rst_val);
        for (int k = 0; k < NI; k++) begin
            if (rst_n) begin
                yq_m[k] = y_m[k];
                st_m[k] = st_m[k] | sel_m[k];
            end else begin
                yq_m[k] = 1'b0;
                st_m[k] = 1'b0;
            end
        end
        rst_n = rst_val;
        if (!rst_val) begin
            yq_m = '0;
            st_m = '0;
        end
        for (int k = 0; k < NI; k++) begin
            y_m[k]   = ref_y(k, xv[k], ssv[k]);
            sel_m[k] = ref_err(k, ssv[k]);
        end
        sb.push_back('{y_m, sel_m, yq_m, st_m});
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %b expected %b (lanes N=6,2,5,8) at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("y",          y_a,   e.y);
            chk("sel_err",    sel_a, e.sel);
            chk("y_q",        yq_a,  e.yq);
            chk("err_sticky", st_a,  e.st);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        y_m = '0; sel_m = '0; yq_m = '0; st_m = '0;
        for (int k = 0; k < NI; k++) begin
            xv[k]  = '0;
            ssv[k] = '0;
        end
        @(posedge clk);
        #1;

        repeat (2) begin
            for (int k = 0; k < NI; k++) begin
                xv[k]  = 8'($urandom);
                ssv[k] = 3'($urandom_range(7));
            end
            step(1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            xv[0]  = 8'b1010_1100;
            ssv[0] = 3'(i);
            xv[1]  = 8'b0001_0110;
            ssv[1] = (i < 3) ? 3'(5 + i) : 3'd2;
            xv[2]  = 8'b0000_0010;
            ssv[2] = 3'(i & 1);
            xv[3]  = 8'($urandom);
            ssv[3] = 3'(i);
            step(1'b1);
        end

        for (int k = 0; k < NI; k++) begin
            xv[k]  = 8'hFF;
            ssv[k] = 3'd1;
        end
        step(1'b1);
        step(1'b1);
        step(1'b0);
        for (int k = 0; k < NI; k++) xv[k] = 8'($urandom);
        step(1'b0);
        step(1'b1);

        for (int c = 0; c < 1000; c++) begin
            for (int k = 0; k < NI; k++) begin
                xv[k]  = 8'($urandom);
                ssv[k] = 3'($urandom_range(7));
            end
            step(($urandom_range(99) == 0) ? 1'b0 : 1'b1);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
